// File: rtl/ysyx_22040365_id_stage_pkg.sv
// Shared decode definitions for the ID stage: opcodes, inst_type bit positions, immediate formats.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ysyx_22040365_defines;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // Bit positions inside the one-hot inst_type vector (LUI is bit 0).
    localparam int IT_LUI      = 0;
    localparam int IT_AUIPC    = 1;
    localparam int IT_JAL      = 2;
    localparam int IT_JALR     = 3;
    localparam int IT_BRANCH   = 4;
    localparam int IT_LOAD     = 5;
    localparam int IT_STORE    = 6;
    localparam int IT_OP_IMM   = 7;
    localparam int IT_OP       = 8;
    localparam int IT_OP_IMM32 = 9;
    localparam int IT_OP32     = 10;
    localparam int IT_SYSTEM   = 11;
    localparam int IT_W        = 12;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } imm_fmt_e;

    // Immediate is always carried at 64 bits; narrower datapaths take the low bits,
    // which is still a correct sign extension because every format extends from inst[31].
    typedef struct packed {
        logic [IT_W-1:0] inst_type;
        logic [2:0]      func3;
        logic [6:0]      func7;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [63:0]     imm;
        logic            ren_rs1;
        logic            ren_rs2;
        logic            wen_rd;
        logic            illegal;
    } dec_t;

    function automatic logic [63:0] sext_imm(input logic [31:0] inst, input imm_fmt_e fmt);
        logic [63:0] imm;
        case (fmt)
            FMT_I:   imm = {{52{inst[31]}}, inst[31:20]};
            FMT_S:   imm = {{52{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   imm = {{52{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   imm = {{32{inst[31]}}, inst[31:12], 12'b0};
            FMT_J:   imm = {{44{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = 64'd0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/ysyx_22040365_id_stage_if.sv
// Fetch-in / decode-out handshake bundle of the ID stage, plus flush.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both sides; master = IFU/EXU side, slave = ID stage.
interface ysyx_22040365_id_stage_if #(
    parameter int XLEN = 64,
    parameter int PC_W = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [PC_W-1:0] in_pc;
    logic [31:0]     in_inst;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [11:0]     out_inst_type;
    logic [2:0]      out_func3;
    logic [6:0]      out_func7;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic [XLEN-1:0] out_imm;
    logic            out_ren_rs1;
    logic            out_ren_rs2;
    logic            out_wen_rd;
    logic            out_illegal;

    modport master (
        output in_valid, in_pc, in_inst, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_inst_type, out_func3, out_func7,
               out_rs1, out_rs2, out_rd, out_imm, out_ren_rs1, out_ren_rs2,
               out_wen_rd, out_illegal
    );

    modport slave (
        input  in_valid, in_pc, in_inst, flush, out_ready,
        output in_ready, out_valid, out_pc, out_inst_type, out_func3, out_func7,
               out_rs1, out_rs2, out_rd, out_imm, out_ren_rs1, out_ren_rs2,
               out_wen_rd, out_illegal
    );
endinterface

// File: rtl/ysyx_22040365_id_dec.sv
// Combinational RV64I decoder: raw instruction in, decoded bundle out.
// Latency: 0 cycles.
// Backpressure: none (pure logic). Ports: inst (32b) in, dec (dec_t) out.
module ysyx_22040365_id_dec
    import ysyx_22040365_defines::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0] inst,
    output dec_t        dec
);
    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [IT_W-1:0] itype;
    imm_fmt_e        fmt;
    logic            ren1;
    logic            ren2;
    logic            wen;
    logic            ill;
    logic            wen_eff;

    assign opc = inst[6:0];
    assign f3  = inst[14:12];

    always_comb begin
        itype = '0;
        fmt   = FMT_R;
        ren1  = 1'b0;
        ren2  = 1'b0;
        wen   = 1'b0;
        ill   = 1'b0;
        // Opcodes with inst[1:0] != 2'b11 never match a listed opcode and fall to default.
        case (opc)
            OPC_LUI:      begin itype[IT_LUI] = 1'b1;   fmt = FMT_U; wen = 1'b1; end
            OPC_AUIPC:    begin itype[IT_AUIPC] = 1'b1; fmt = FMT_U; wen = 1'b1; end
            OPC_JAL:      begin itype[IT_JAL] = 1'b1;   fmt = FMT_J; wen = 1'b1; end
            OPC_JALR: begin
                itype[IT_JALR] = 1'b1; fmt = FMT_I; ren1 = 1'b1; wen = 1'b1;
                ill = (f3 != 3'd0);
            end
            OPC_BRANCH: begin
                itype[IT_BRANCH] = 1'b1; fmt = FMT_B; ren1 = 1'b1; ren2 = 1'b1;
                ill = (f3[2:1] == 2'b01);
            end
            OPC_LOAD: begin
                itype[IT_LOAD] = 1'b1; fmt = FMT_I; ren1 = 1'b1; wen = 1'b1;
                ill = (f3 == 3'd7);
            end
            OPC_STORE: begin
                itype[IT_STORE] = 1'b1; fmt = FMT_S; ren1 = 1'b1; ren2 = 1'b1;
                ill = f3[2];
            end
            OPC_OP_IMM:   begin itype[IT_OP_IMM] = 1'b1; fmt = FMT_I; ren1 = 1'b1; wen = 1'b1; end
            OPC_OP:       begin itype[IT_OP] = 1'b1; ren1 = 1'b1; ren2 = 1'b1; wen = 1'b1; end
            OPC_OP_IMM32: begin
                itype[IT_OP_IMM32] = 1'b1; fmt = FMT_I; ren1 = 1'b1; wen = 1'b1;
                ill = (XLEN == 32);
            end
            OPC_OP32: begin
                itype[IT_OP32] = 1'b1; ren1 = 1'b1; ren2 = 1'b1; wen = 1'b1;
                ill = (XLEN == 32);
            end
            OPC_SYSTEM: begin
                itype[IT_SYSTEM] = 1'b1; fmt = FMT_I;
                ill = !((inst == INST_ECALL) || (inst == INST_EBREAK));
            end
            default: ill = 1'b1;
        endcase
        // Illegal bundles still flow downstream, but carry no class, enables or immediate.
        if (ill) begin
            itype = '0;
            fmt   = FMT_R;
            ren1  = 1'b0;
            ren2  = 1'b0;
            wen   = 1'b0;
        end
    end

    // Writes to x0 are dropped here so the EXU/WBU never need to special-case rd==0.
    assign wen_eff = wen && (inst[11:7] != 5'd0);

    always_comb begin
        dec           = '0;
        dec.inst_type = itype;
        dec.func3     = f3;
        dec.func7     = inst[31:25];
        dec.rs1       = ren1 ? inst[19:15] : 5'd0;
        dec.rs2       = ren2 ? inst[24:20] : 5'd0;
        dec.rd        = wen_eff ? inst[11:7] : 5'd0;
        dec.imm       = sext_imm(inst, fmt);
        dec.ren_rs1   = ren1;
        dec.ren_rs2   = ren2;
        dec.wen_rd    = wen_eff;
        dec.illegal   = ill;
    end
endmodule

// File: rtl/ysyx_22040365_id_stage.sv
// Registered RV64I decode stage between IFU and EXU: decodes {pc, inst}, holds result in main/skid regs.
// Latency: 1 cycle accept-to-out_valid; 1 bundle/cycle with out_ready high.
// Backpressure: SKID_EN=1 -> 2 entries, in_ready = ~skid_vld (register); SKID_EN=0 -> in_ready = ~out_valid | out_ready.
// Ports: clk, rst_n (async, active low), bus (slave modport: in_* fetch side, out_* decoded side, flush).
module ysyx_22040365_id_stage
    import ysyx_22040365_defines::*;
#(
    parameter int XLEN    = 64,
    parameter int PC_W    = 64,
    parameter bit SKID_EN = 1'b1
) (
    input logic                         clk,
    input logic                         rst_n,
    ysyx_22040365_id_stage_if.slave     bus
);
    typedef struct packed {
        logic [PC_W-1:0] pc;
        dec_t            dec;
    } ent_t;

    dec_t  new_dec;
    ent_t  new_ent;
    ent_t  main_q, main_n, skid_q, skid_n;
    logic  main_vld, main_vld_n, skid_vld, skid_vld_n;
    logic  in_ready;
    logic  accept;

    ysyx_22040365_id_dec #(.XLEN(XLEN)) u_dec (
        .inst (bus.in_inst),
        .dec  (new_dec)
    );

    assign new_ent = '{pc: bus.in_pc, dec: new_dec};

    assign in_ready = SKID_EN ? ~skid_vld : (~main_vld | bus.out_ready);
    assign accept   = bus.in_valid & in_ready;

    always_comb begin
        main_vld_n = main_vld;
        main_n     = main_q;
        skid_vld_n = skid_vld;
        skid_n     = skid_q;
        if (bus.flush) begin
            // Anything accepted this cycle is dropped along with the held entries.
            main_vld_n = 1'b0;
            skid_vld_n = 1'b0;
        end else if (!main_vld || bus.out_ready) begin
            // Main is free this cycle. in_ready is low whenever skid holds data,
            // so a skid refill and a new accept can never collide here.
            if (skid_vld) begin
                main_vld_n = 1'b1;
                main_n     = skid_q;
                skid_vld_n = 1'b0;
            end else begin
                main_vld_n = accept;
                if (accept) begin
                    main_n = new_ent;
                end
            end
        end else if (accept && SKID_EN) begin
            skid_vld_n = 1'b1;
            skid_n     = new_ent;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_vld <= 1'b0;
            main_q   <= '0;
            skid_vld <= 1'b0;
            skid_q   <= '0;
        end else begin
            main_vld <= main_vld_n;
            main_q   <= main_n;
            skid_vld <= skid_vld_n;
            skid_q   <= skid_n;
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = main_vld;
    assign bus.out_pc        = main_q.pc;
    assign bus.out_inst_type = main_q.dec.inst_type;
    assign bus.out_func3     = main_q.dec.func3;
    assign bus.out_func7     = main_q.dec.func7;
    assign bus.out_rs1       = main_q.dec.rs1;
    assign bus.out_rs2       = main_q.dec.rs2;
    assign bus.out_rd        = main_q.dec.rd;
    assign bus.out_imm       = main_q.dec.imm[XLEN-1:0];
    assign bus.out_ren_rs1   = main_q.dec.ren_rs1;
    assign bus.out_ren_rs2   = main_q.dec.ren_rs2;
    assign bus.out_wen_rd    = main_q.dec.wen_rd;
    assign bus.out_illegal   = main_q.dec.illegal;
endmodule

// File: tb/tb_ysyx_22040365_id_stage.sv
module tb_ysyx_22040365_id_stage;
    import ysyx_22040365_defines::*;

    localparam int XLEN = 64;
    localparam int PC_W = 64;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    ysyx_22040365_id_stage_if #(.XLEN(XLEN), .PC_W(PC_W)) bus ();

    ysyx_22040365_id_stage #(.XLEN(XLEN), .PC_W(PC_W), .SKID_EN(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [11:0] itype;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [63:0] imm;
        logic        ren1;
        logic        ren2;
        logic        wen;
        logic        ill;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic vld, input logic [63:0] pc, input logic [31:0] inst);
        bus.in_valid = vld;
        bus.in_pc    = pc;
        bus.in_inst  = inst;
    endtask

    function automatic logic [11:0] oh(input int idx);
        logic [11:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_pc     = '0;
        bus.in_inst   = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;

        //            inst          itype               f3    f7     rs1 rs2 rd  imm                      r1 r2 w  ill
        vecs[0] = '{32'h00500093, oh(IT_OP_IMM),     3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 64'd5,                  1, 0, 1, 0};
        vecs[1] = '{32'hff010113, oh(IT_OP_IMM),     3'd0, 7'h7f, 5'd2, 5'd0, 5'd2, 64'hFFFF_FFFF_FFFF_FFF0, 1, 0, 1, 0};
        vecs[2] = '{32'h00113423, oh(IT_STORE),      3'd3, 7'h00, 5'd2, 5'd1, 5'd0, 64'd8,                  1, 1, 0, 0};
        vecs[3] = '{32'h123452b7, oh(IT_LUI),        3'd5, 7'h09, 5'd0, 5'd0, 5'd5, 64'h1234_5000,          0, 0, 1, 0};
        vecs[4] = '{32'hffdff06f, oh(IT_JAL),        3'd7, 7'h7f, 5'd0, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 0};
        vecs[5] = '{32'h00208463, oh(IT_BRANCH),     3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 64'd8,                  1, 1, 0, 0};
        vecs[6] = '{32'h0020a463, 12'h000,           3'd2, 7'h00, 5'd0, 5'd0, 5'd0, 64'd0,                  0, 0, 0, 1};
        vecs[7] = '{32'h002081b3, oh(IT_OP),         3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 64'd0,                  1, 1, 1, 0};
        vecs[8] = '{32'h0010809b, oh(IT_OP_IMM32),   3'd0, 7'h00, 5'd1, 5'd0, 5'd1, 64'd1,                  1, 0, 1, 0};
        vecs[9] = '{32'h00000000, 12'h000,           3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 64'd0,                  0, 0, 0, 1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_pc", bus.out_pc, 64'd0);
        chk("rst_out_imm", bus.out_imm, 64'd0);
        chk("rst_inst_type", 64'(bus.out_inst_type), 64'd0);
        rst_n = 1'b1;
        step();

        // Back-to-back decode vectors, out_ready held high: one result per cycle.
        for (int i = 0; i < 10; i++) begin
            chk("vec_in_ready", 64'(bus.in_ready), 64'd1);
            offer(1'b1, 64'h8000_0000 + 64'(4 * i), vecs[i].inst);
            step();
            chk("vec_out_valid", 64'(bus.out_valid), 64'd1);
            chk("vec_pc", bus.out_pc, 64'h8000_0000 + 64'(4 * i));
            chk("vec_type", 64'(bus.out_inst_type), 64'(vecs[i].itype));
            chk("vec_f3", 64'(bus.out_func3), 64'(vecs[i].f3));
            chk("vec_f7", 64'(bus.out_func7), 64'(vecs[i].f7));
            chk("vec_rs1", 64'(bus.out_rs1), 64'(vecs[i].rs1));
            chk("vec_rs2", 64'(bus.out_rs2), 64'(vecs[i].rs2));
            chk("vec_rd", 64'(bus.out_rd), 64'(vecs[i].rd));
            chk("vec_imm", bus.out_imm, vecs[i].imm);
            chk("vec_ren1", 64'(bus.out_ren_rs1), 64'(vecs[i].ren1));
            chk("vec_ren2", 64'(bus.out_ren_rs2), 64'(vecs[i].ren2));
            chk("vec_wen", 64'(bus.out_wen_rd), 64'(vecs[i].wen));
            chk("vec_ill", 64'(bus.out_illegal), 64'(vecs[i].ill));
        end
        // EBREAK decodes as legal SYSTEM
        offer(1'b1, 64'h9000, 32'h00100073);
        step();
        chk("ebreak_type", 64'(bus.out_inst_type), 64'(oh(IT_SYSTEM)));
        chk("ebreak_ill", 64'(bus.out_illegal), 64'd0);
        chk("ebreak_imm", bus.out_imm, 64'd1);
        offer(1'b0, 64'h0, 32'h0);
        step();
        chk("idle_out_valid", 64'(bus.out_valid), 64'd0);

        // Backpressure: A into main, B into skid, C refused.
        bus.out_ready = 1'b0;
        offer(1'b1, 64'h100, 32'h00500093);
        step();
        chk("bp_a_valid", 64'(bus.out_valid), 64'd1);
        chk("bp_a_pc", bus.out_pc, 64'h100);
        chk("bp_rdy_after_a", 64'(bus.in_ready), 64'd1);
        offer(1'b1, 64'h104, 32'hff010113);
        step();
        chk("bp_hold_pc", bus.out_pc, 64'h100);
        chk("bp_hold_imm", bus.out_imm, 64'd5);
        chk("bp_rdy_full", 64'(bus.in_ready), 64'd0);
        offer(1'b1, 64'h108, 32'h00113423);
        step();
        chk("bp_hold_pc2", bus.out_pc, 64'h100);
        chk("bp_rdy_full2", 64'(bus.in_ready), 64'd0);
        bus.out_ready = 1'b1;
        step();
        chk("bp_b_pc", bus.out_pc, 64'h104);
        chk("bp_b_imm", bus.out_imm, 64'hFFFF_FFFF_FFFF_FFF0);
        chk("bp_rdy_free", 64'(bus.in_ready), 64'd1);
        step();
        chk("bp_c_valid", 64'(bus.out_valid), 64'd1);
        chk("bp_c_pc", bus.out_pc, 64'h108);
        chk("bp_c_type", 64'(bus.out_inst_type), 64'(oh(IT_STORE)));
        offer(1'b0, 64'h0, 32'h0);
        step();
        chk("bp_drained", 64'(bus.out_valid), 64'd0);

        // Flush with two entries held and a new offer in the flush cycle.
        bus.out_ready = 1'b0;
        offer(1'b1, 64'h200, 32'h00500093);
        step();
        offer(1'b1, 64'h204, 32'h00500093);
        step();
        chk("fl_full", 64'(bus.in_ready), 64'd0);
        bus.flush = 1'b1;
        offer(1'b1, 64'h208, 32'h00500093);
        step();
        bus.flush = 1'b0;
        offer(1'b0, 64'h0, 32'h0);
        chk("fl_out_valid", 64'(bus.out_valid), 64'd0);
        chk("fl_in_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("fl_no_ghost", 64'(bus.out_valid), 64'd0);
        end

        // Flush on the same cycle as an accept into an empty stage drops it too.
        bus.flush = 1'b1;
        offer(1'b1, 64'h210, 32'h00500093);
        step();
        bus.flush = 1'b0;
        offer(1'b0, 64'h0, 32'h0);
        chk("fl_accept_drop", 64'(bus.out_valid), 64'd0);

        // Asynchronous reset in the middle of a stall.
        bus.out_ready = 1'b0;
        offer(1'b1, 64'h300, 32'h00500093);
        step();
        offer(1'b0, 64'h0, 32'h0);
        chk("ar_valid_before", 64'(bus.out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid_drop", 64'(bus.out_valid), 64'd0);
        chk("ar_in_ready", 64'(bus.in_ready), 64'd1);
        chk("ar_pc_clear", bus.out_pc, 64'd0);
        step();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        step();
        chk("ar_idle", 64'(bus.out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ysyx_22040365_id_stage.md
Name: ysyx_22040365_id_stage

Overview:
Registered RV64I instruction-decode stage for the NPC pipeline, between IFU and EXU.
- Accepts {pc, inst} over a valid/ready handshake and decodes opcode class, register indices, read/write enables and the sign-extended immediate.
- Presents the decoded bundle one cycle later through a 2-entry skid buffer, so in_ready is a pure register output.
- Supports pipeline flush and flags illegal encodings.

Parameters:
XLEN, 64, datapath and immediate width (32 or 64)
PC_W, 64, program-counter width carried alongside
SKID_EN, 1, 1 = 2-entry skid buffer (registered in_ready); 0 = single entry, in_ready = ~out_valid | out_ready

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  fetch bundle valid
in_ready  out  1  stage can accept
in_pc  in  PC_W  instruction address
in_inst  in  32  raw instruction
flush  in  1  discard all held entries this cycle
out_valid  out  1  decoded bundle valid
out_ready  in  1  EXU accepts
out_pc  out  PC_W  passthrough pc
out_inst_type  out  12  one-hot class: LUI,AUIPC,JAL,JALR,BRANCH,LOAD,STORE,OP_IMM,OP,OP_IMM32,OP32,SYSTEM
out_func3  out  3  inst[14:12]
out_func7  out  7  inst[31:25]
out_rs1  out  5  inst[19:15]; 0 when ren_rs1=0
out_rs2  out  5  inst[24:20]; 0 when ren_rs2=0
out_rd  out  5  inst[11:7]; 0 when wen_rd=0
out_imm  out  XLEN  sign-extended immediate for the decoded format
out_ren_rs1  out  1  rs1 read needed
out_ren_rs2  out  1  rs2 read needed
out_wen_rd  out  1  rd write; forced 0 when rd==0
out_illegal  out  1  unrecognised opcode/func3 combination

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, in_ready=1, skid empty, all out_* data fields 0.
- Decode is combinational on in_inst; the result is registered on accept (in_valid & in_ready). Latency: 1 cycle from accept to out_valid.
- Immediate formats:
  - I: JALR, LOAD, OP_IMM, OP_IMM32, SYSTEM
  - S: STORE
  - B: BRANCH
  - U: LUI, AUIPC; value inst[31:12]<<12, sign-extended from bit 31
  - J: JAL
  - R: OP, OP32; imm=0
- All immediates sign-extend from inst[31] to XLEN.
- Register enables:
  - ren_rs1: JALR, BRANCH, LOAD, STORE, OP_IMM, OP, OP_IMM32, OP32
  - ren_rs2: BRANCH, STORE, OP, OP32
  - wen_rd: LUI, AUIPC, JAL, JALR, LOAD, OP_IMM, OP, OP_IMM32, OP32
- Illegal:
  - opcode[1:0]!=2'b11 or unlisted opcode
  - BRANCH func3 in {2,3}; LOAD func3==7; STORE func3>3; JALR func3!=0
  - SYSTEM other than ECALL (0x00000073) or EBREAK (0x00100073)
  - XLEN=32 and opcode is OP_IMM32/OP32
  - On illegal: inst_type=0, all enables 0, imm=0, illegal=1; the bundle still flows downstream.
- Output hold: while out_valid & ~out_ready, all out_* fields are stable.
- Skid (SKID_EN=1):
  - Main register drives the outputs.
  - in_ready = ~skid_full, registered.
  - An accept while the main register is stalled writes the skid.
  - When out_ready frees the main register, skid moves to main in the same cycle.
  - Max 2 entries; order preserved.
- Simultaneous accept and drain with the main register valid and skid empty: main takes the new bundle, no bubble.
- Flush: next cycle out_valid=0, skid empty, in_ready=1. An accept in the flush cycle is discarded. Flush has priority over all other events.
- Throughput: 1 bundle/cycle when out_ready is held high.

Decomposition:
- Package ysyx_22040365_defines: opcode constants, inst_type bit indices, immediate-format enum, ECALL/EBREAK encodings.
- Sub-module ysyx_22040365_id_dec: purely combinational inst to decoded bundle. It is instantiated once; the stage wraps it with the skid/handshake logic.

Test Plan:
1. Reset, then in 0x00500093 (addi x1,x0,5), out_ready=1 -> next cycle out_valid=1, OP_IMM, rd=1, rs1=0, imm=5, ren_rs1=1, wen_rd=1, illegal=0.
2. 0xff010113 (addi sp,sp,-16), then 0x00113423 (sd x1,8(x2)) back-to-back -> first: imm=0xFFFF_FFFF_FFFF_FFF0. Second: STORE, rs1=2, rs2=1, imm=8, wen_rd=0. One per cycle, no bubble.
3. 0x123452b7 (lui x5,0x12345) -> rd=5, imm=0x12345000. Then 0xffdff06f (jal x0,-4) -> JAL, imm=-4, wen_rd=0 (rd=0).
4. Backpressure: out_ready=0 for 3 cycles with 3 offered bundles -> first two held (main+skid), in_ready=0 on the third. On release, outputs appear in order with no loss or duplication.
5. Flush with 2 entries held and in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed bundles never appear.
6. 0x00000000 -> illegal=1, inst_type=0. 0x00100073 -> SYSTEM, illegal=0. Assert rst_n low mid-stall -> out_valid drops immediately, without waiting for a clock edge.
